// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter (PicoRV32 core + host loader) in front of one shared word memory.
// Build option: define MEMARB_ROUND_ROBIN_EN for round-robin, otherwise m0 has fixed priority.
module picorv32_mem_arbiter #(
    parameter int MEM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        err,
    output logic [15:0] m0_grants,
    output logic [15:0] m1_grants
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1,
        OOR
    } state_e;

    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        err_q, err_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    logic        req;
    logic        win;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;
    logic        win_ok;

    assign req = m0_valid | m1_valid;

`ifdef MEMARB_ROUND_ROBIN_EN
    // last_q names the master served most recently; reset value favours m0
    logic last_q, last_d;

    always_comb begin
        if (m0_valid && m1_valid) begin
            win = ~last_q;
        end else begin
            win = ~m0_valid;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && req) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = ~m0_valid;
`endif

    assign win_addr  = win ? m1_addr  : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;
    assign win_wstrb = win ? m1_wstrb : m0_wstrb;
    assign win_ok    = {1'b0, win_addr} < LIMIT;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        err_d   = err_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    gnt_d   = win;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    wstrb_d = win_wstrb;
                    if (win) begin
                        cnt1_d = cnt1_q + 16'd1;
                    end else begin
                        cnt0_d = cnt0_q + 16'd1;
                    end
                    if (!win_ok) begin
                        state_d = OOR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = win ? BUSY1 : BUSY0;
                    end
                end
            end
            BUSY0, BUSY1: begin
                if (s_ready) begin
                    state_d = IDLE;
                end
            end
            OOR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are latched at grant so a master may drop valid mid-transfer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        if (resetn) begin
            unique case (state_q)
                BUSY0: begin
                    s_valid  = 1'b1;
                    s_addr   = addr_q;
                    s_wdata  = wdata_q;
                    s_wstrb  = wstrb_q;
                    m0_ready = s_ready;
                    if (s_ready) begin
                        m0_rdata = s_rdata;
                    end
                end
                BUSY1: begin
                    s_valid  = 1'b1;
                    s_addr   = addr_q;
                    s_wdata  = wdata_q;
                    s_wstrb  = wstrb_q;
                    m1_ready = s_ready;
                    if (s_ready) begin
                        m1_rdata = s_rdata;
                    end
                end
                OOR: begin
                    if (gnt_q) begin
                        m1_ready = 1'b1;
                    end else begin
                        m0_ready = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err       = err_q;
    assign m0_grants = cnt0_q;
    assign m1_grants = cnt1_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory/arbitration model.
module tb_picorv32_mem_arbiter;

`ifdef MEMARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] MEM_BYTES = 32'h8000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err;
    logic [15:0] m0_grants, m1_grants;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.MEM_WORDS(8192)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .err(err), .m0_grants(m0_grants), .m1_grants(m1_grants)
    );

    // Shared memory with a programmable number of wait states per access
    logic [31:0] smem [0:8191];
    int unsigned next_wait = 0;
    int unsigned wcnt = 0;
    logic        bd_we;
    logic [12:0] bd_idx;
    logic [31:0] bd_dat;

    assign s_ready = s_valid && (wcnt == 0);
    assign s_rdata = smem[s_addr[14:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            smem[bd_idx] <= bd_dat;
        end else if (s_valid && s_ready) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) smem[s_addr[14:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
        if (!s_valid || s_ready) wcnt <= next_wait;
        else wcnt <= wcnt - 1;
    end

    // Reference model state
    logic [31:0] ref_mem [0:8191];
    logic [15:0] exp_g [2];
    logic        exp_err;
    int          last_srv;
    logic [31:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic [3:0]  t_wstrb [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] d);
        bd_idx = 13'(idx);
        bd_dat = d;
        bd_we  = 1'b1;
        @(posedge clk); #1;
        bd_we  = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic model_txn(input int x, output logic [31:0] rd);
        logic [12:0] idx;
        if (t_addr[x] < MEM_BYTES) begin
            idx = t_addr[x][14:2];
            rd  = ref_mem[idx];
            for (int b = 0; b < 4; b++) begin
                if (t_wstrb[x][b]) ref_mem[idx][8*b +: 8] = t_wdata[x][8*b +: 8];
            end
        end else begin
            rd = '0;
            exp_err = 1'b1;
        end
        exp_g[x] = exp_g[x] + 16'd1;
        last_srv = x;
    endtask

    task automatic model_reset();
        exp_g[0] = '0;
        exp_g[1] = '0;
        exp_err  = 1'b0;
        last_srv = 1;
    endtask

    // One request per participating master; each drops valid after its ready pulse
    task automatic run(input bit r0, input bit r1);
        bit p0, p1;
        int ord [$];
        int eord [$];
        logic [31:0] rd [2];
        int lat [2];
        int svc, esvc, sel, first, x;
        logic [31:0] erd;
        p0 = r0; p1 = r1; svc = 0; esvc = 0;
        rd[0] = '0; rd[1] = '0; lat[0] = 0; lat[1] = 0;
        m0_valid = r0; m0_addr = t_addr[0]; m0_wdata = t_wdata[0]; m0_wstrb = t_wstrb[0];
        m1_valid = r1; m1_addr = t_addr[1]; m1_wdata = t_wdata[1]; m1_wstrb = t_wstrb[1];
        for (int k = 1; k <= 60 && (p0 || p1); k++) begin
            @(negedge clk);
            if (s_valid) begin
                svc++;
                sel = (!r1 || (r0 && s_addr === t_addr[0])) ? 0 : 1;
                chk("s_addr", s_addr, t_addr[sel]);
                chk("s_wdata", s_wdata, t_wdata[sel]);
                chk("s_wstrb", 32'(s_wstrb), 32'(t_wstrb[sel]));
            end
            chk("one_ready", 32'(m0_ready & m1_ready), 0);
            if (m0_ready) begin
                chk("m0_ready_expected", 32'(p0), 1);
                rd[0] = m0_rdata; lat[0] = k; p0 = 1'b0; ord.push_back(0);
            end else begin
                chk("m0_rdata_idle", m0_rdata, 0);
            end
            if (m1_ready) begin
                chk("m1_ready_expected", 32'(p1), 1);
                rd[1] = m1_rdata; lat[1] = k; p1 = 1'b0; ord.push_back(1);
            end else begin
                chk("m1_rdata_idle", m1_rdata, 0);
            end
            @(posedge clk); #1;
            if (!p0) m0_valid = 1'b0;
            if (!p1) m1_valid = 1'b0;
        end
        chk("timeout", 32'({p0, p1}), 0);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        if (r0 && r1) begin
            first = RR ? ((last_srv == 0) ? 1 : 0) : 0;
            eord = '{first, 1 - first};
        end else begin
            eord = '{r0 ? 0 : 1};
        end
        chk("order_len", ord.size(), eord.size());
        foreach (eord[i]) begin
            x = eord[i];
            if (i < ord.size()) chk("order", ord[i], x);
            if (t_addr[x] < MEM_BYTES) esvc += 1 + int'(next_wait);
            model_txn(x, erd);
            chk(x == 1 ? "m1_rdata" : "m0_rdata", rd[x], erd);
        end
        if (!(r0 && r1)) begin
            chk("latency", lat[eord[0]],
                (t_addr[eord[0]] < MEM_BYTES) ? 2 + next_wait : 2);
        end
        chk("s_valid_cycles", svc, esvc);
        chk("m0_grants", 32'(m0_grants), 32'(exp_g[0]));
        chk("m1_grants", 32'(m1_grants), 32'(exp_g[1]));
        chk("err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int got [$];
        logic [31:0] grd [$];
        logic [31:0] erd;
        logic [31:0] hrd;
        int x, pick;
        bit hit;

        resetn = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            t_addr[i] = '0; t_wdata[i] = '0; t_wstrb[i] = '0;
        end

        // Reset with a pending m0 request: outputs must stay quiet
        bd_write(4, 32'hDEADBEEF);
        m0_valid = 1'b1; m0_addr = 32'h10;
        @(negedge clk);
        chk("rst_m0_ready", 32'(m0_ready), 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_s_wstrb", 32'(s_wstrb), 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_m0_grants", 32'(m0_grants), 0);
        chk("rst_m1_grants", 32'(m1_grants), 0);
        @(posedge clk); #1;

        // Single m0 read straight out of reset
        t_addr[0] = 32'h10; t_wstrb[0] = 4'h0;
        resetn = 1'b1;
        run(1'b1, 1'b0);

        for (int i = 0; i < 64; i++) bd_write(i, $urandom);

        // Boundary words
        bd_write(8191, 32'hCAFEF00D);
        t_addr[0] = 32'h7FFC; t_wstrb[0] = 4'h0;
        run(1'b1, 1'b0);
        t_addr[0] = 32'h8000;
        run(1'b1, 1'b0);

        // Out-of-range write from m1
        t_addr[1] = 32'h8000; t_wdata[1] = 32'h12345678; t_wstrb[1] = 4'hF;
        run(1'b0, 1'b1);
        @(negedge clk);
        chk("oor_single_pulse", 32'(m1_ready), 0);
        @(posedge clk); #1;

        // Wait states
        next_wait = 3;
        t_addr[0] = 32'h20; t_wstrb[0] = 4'h0;
        run(1'b1, 1'b0);
        t_addr[0] = 32'h24; t_wdata[0] = 32'h0BADF00D; t_wstrb[0] = 4'h5;
        run(1'b1, 1'b0);
        next_wait = 0;

        // Reset while m1 is in flight
        next_wait = 5;
        @(posedge clk); #1;
        m1_valid = 1'b1; m1_addr = 32'h84; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy_s_valid", 32'(s_valid), 1);
        chk("mid_busy_m1_ready", 32'(m1_ready), 0);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_m1_ready", 32'(m1_ready), 0);
        chk("mid_rst_s_valid", 32'(s_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_m1_grants", 32'(m1_grants), 0);
        chk("mid_rst_m0_grants", 32'(m0_grants), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_s_valid2", 32'(s_valid), 0);
        chk("mid_rst_m1_ready2", 32'(m1_ready), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        m1_valid = 1'b0;
        next_wait = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_m1_ready", 32'(m1_ready), 0);
            @(posedge clk); #1;
        end

        // Both masters hold valid across four transactions
        t_addr[0] = 32'h0;  t_wstrb[0] = 4'h0;
        t_addr[1] = 32'h80; t_wstrb[1] = 4'h0;
        m0_valid = 1'b1; m0_addr = t_addr[0]; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = t_addr[1]; m1_wstrb = 4'h0;
        for (int k = 0; k < 40 && got.size() < 4; k++) begin
            @(negedge clk);
            if (m0_ready) begin got.push_back(0); grd.push_back(m0_rdata); end
            if (m1_ready) begin got.push_back(1); grd.push_back(m1_rdata); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            x = RR ? ((last_srv == 0) ? 1 : 0) : 0;
            model_txn(x, erd);
            chk("hold_order", (i < got.size()) ? got[i] : 7, x);
            chk("hold_rdata", (i < grd.size()) ? grd[i] : 32'hBAD0BAD0, erd);
        end
`ifdef MEMARB_ROUND_ROBIN_EN
        m0_valid = 1'b0;
        m1_valid = 1'b0;
`else
        m0_valid = 1'b0;
        hit = 1'b0;
        hrd = '0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (m1_ready) begin hit = 1'b1; hrd = m1_rdata; end
            @(posedge clk); #1;
        end
        chk("m1_after_m0_drop", 32'(hit), 1);
        model_txn(1, erd);
        chk("m1_after_drop_rdata", hrd, erd);
        m1_valid = 1'b0;
`endif
        @(negedge clk);
        chk("hold_m0_grants", 32'(m0_grants), 32'(exp_g[0]));
        chk("hold_m1_grants", 32'(m1_grants), 32'(exp_g[1]));
        @(posedge clk); #1;

        // Randomized traffic with occasional out-of-range accesses
        for (int it = 0; it < 60; it++) begin
            pick = $urandom_range(0, 2);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 7) == 0)
                    t_addr[m] = 32'h8000 + 4 * $urandom_range(0, 255);
                else
                    t_addr[m] = 4 * (32 * m + $urandom_range(0, 31));
                t_wdata[m] = $urandom;
                t_wstrb[m] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
            next_wait = $urandom_range(0, 3);
            run(pick != 1, pick != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
